// File: rtl/smg_scan_driver.sv
// Multiplexed seven-segment scan driver: a per-frame shadowed hex display with
// leading-zero blanking, decimal points and PWM brightness control.
module smg_scan_driver #(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   Number_Sig,
    input  logic [DIGITS-1:0]     DP_Sig,
    input  logic                  Blank_LZ,
    input  logic [3:0]            Bright,
    output logic [7:0]            SMG_Data,
    output logic [DIGITS-1:0]     Scan_Sig,
    output logic                  Frame_Done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [7:0]        SEG_MASK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_MASK = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    div_cnt;
    logic [2:0]          dig_idx;
    logic [3:0]          pwm_cnt;
    logic [4*DIGITS-1:0] sh_num;
    logic [DIGITS-1:0]   sh_dp;
    logic                sh_blank;

    logic                slot_end;
    logic                frame_end;
    logic [3:0]          nib_p0;
    logic [4*DIGITS-1:0] upper_p0;
    logic                blank_p0;
    logic [7:0]          pat_p0;
    logic [DIGITS-1:0]   onehot_p0;
    logic                sel_on_p0;

    logic [7:0]          seg_p1;
    logic [DIGITS-1:0]   sel_p1;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Stage p0: decode the current digit from shadow state only
    always_comb begin
        slot_end  = (div_cnt == CNT_W'(SCAN_DIV - 1));
        frame_end = slot_end && (dig_idx == 3'(DIGITS - 1));
        nib_p0    = sh_num[{dig_idx, 2'b00} +: 4];
        // Digit is a leading zero when it and every higher nibble are zero
        upper_p0  = sh_num >> {dig_idx, 2'b00};
        blank_p0  = sh_blank && (dig_idx != 3'd0) && (upper_p0 == '0);
        pat_p0    = {sh_dp[dig_idx], blank_p0 ? 7'h00 : seg7(nib_p0)};
        onehot_p0 = DIGITS'(1) << dig_idx;
        sel_on_p0 = (pwm_cnt <= Bright);
    end

    assign Frame_Done = frame_end && !RST;

    // Stage p1: scan counters, frame shadowing and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt  <= '0;
            dig_idx  <= 3'd0;
            pwm_cnt  <= 4'd0;
            sh_num   <= '0;
            sh_dp    <= '0;
            sh_blank <= 1'b0;
            seg_p1   <= SEG_MASK;
            sel_p1   <= SEL_MASK;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (slot_end) begin
                div_cnt <= '0;
                dig_idx <= (dig_idx == 3'(DIGITS - 1)) ? 3'd0 : dig_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
            if (frame_end) begin
                sh_num   <= Number_Sig;
                sh_dp    <= DP_Sig;
                sh_blank <= Blank_LZ;
            end
            // Segments go dark together with the select so no ghosting leaks out
            if (sel_on_p0) begin
                seg_p1 <= pat_p0 ^ SEG_MASK;
                sel_p1 <= onehot_p0 ^ SEL_MASK;
            end else begin
                seg_p1 <= SEG_MASK;
                sel_p1 <= SEL_MASK;
            end
        end
    end

    assign SMG_Data = seg_p1;
    assign Scan_Sig = sel_p1;

endmodule
